// File: rtl/record_fifo.sv
// Word-in / record-out FIFO: packs words into records, supports flush with padding and a length tag.
// Define RECORD_FIFO_STATS_EN to add overflow/flush statistics counters.
module record_fifo #(
    parameter int unsigned          WORD_SIZE         = 8,
    parameter int unsigned          RECORD_WORDS      = 4,
    parameter int unsigned          SLOTS             = 4,
    parameter int unsigned          ALMOST_FULL_SLOTS = 1,
    parameter logic [WORD_SIZE-1:0] PAD_WORD          = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [WORD_SIZE-1:0]              in_data,
    output logic                              in_ready,
    input  logic                              flush,
    output logic                              out_valid,
    output logic [RECORD_WORDS*WORD_SIZE-1:0] out_data,
    output logic [$clog2(RECORD_WORDS):0]     out_len,
    input  logic                              out_ready,
    output logic [$clog2(SLOTS):0]            records_level,
    output logic                              almost_full
`ifdef RECORD_FIFO_STATS_EN
    ,
    input  logic                              stats_clr,
    output logic [15:0]                       ovf_cnt,
    output logic [15:0]                       flush_cnt
`endif
);

    localparam int unsigned Storage = SLOTS * RECORD_WORDS;
    localparam int unsigned IdxW    = $clog2(RECORD_WORDS);
    localparam int unsigned AddrW   = $clog2(Storage);
    localparam int unsigned PtrW    = AddrW + 1;
    localparam int unsigned LenW    = IdxW + 1;
    localparam int unsigned LvlW    = $clog2(SLOTS) + 1;
    localparam int unsigned RecW    = PtrW - IdxW;

    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [PtrW-1:0]      used, used_ceil, slots_used;
    logic [PtrW-1:0]      wr_ptr_w, wr_ptr_d;
    logic                 wr_en, commit_full, flush_eff, load;
    logic [AddrW-IdxW-1:0] wr_slot, rd_slot;
    logic [WORD_SIZE-1:0] mem [Storage];
    logic [LenW-1:0]      tag [SLOTS];
    logic [RECORD_WORDS*WORD_SIZE-1:0] rd_data;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign used          = wr_ptr - rd_ptr;
    assign in_ready      = used < PtrW'(Storage);
    assign wr_en         = in_valid && in_ready;
    assign wr_slot       = wr_ptr[AddrW-1:IdxW];
    assign rd_slot       = rd_ptr[AddrW-1:IdxW];
    assign records_level = LvlW'(used >> IdxW);
    assign used_ceil     = used + PtrW'(RECORD_WORDS - 1);
    assign slots_used    = used_ceil >> IdxW;
    assign almost_full   = (SLOTS - 32'(slots_used)) <= ALMOST_FULL_SLOTS;
    assign load          = (!out_valid || out_ready) && (records_level != '0);

    // The same-cycle write lands first; flush then closes whatever partial record remains.
    always_comb begin
        wr_ptr_w    = wr_ptr + PtrW'(wr_en);
        commit_full = wr_en && (wr_ptr_w[IdxW-1:0] == '0);
        flush_eff   = flush && (wr_ptr_w[IdxW-1:0] != '0);
        wr_ptr_d    = wr_ptr_w;
        if (flush_eff) begin
            wr_ptr_d = {wr_ptr_w[PtrW-1:IdxW] + RecW'(1), {IdxW{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr[AddrW-1:0]] <= in_data;
        end
        if (!rst && commit_full) begin
            tag[wr_slot] <= LenW'(RECORD_WORDS);
        end else if (!rst && flush_eff) begin
            tag[wr_slot] <= {1'b0, wr_ptr_w[IdxW-1:0]};
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < RECORD_WORDS; i++) begin
            rd_data[i*WORD_SIZE +: WORD_SIZE] =
                (LenW'(i) < tag[rd_slot]) ? mem[rd_ptr[AddrW-1:0] + AddrW'(i)] : PAD_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            if (load) begin
                rd_ptr    <= rd_ptr + PtrW'(RECORD_WORDS);
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_len   <= tag[rd_slot];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RECORD_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            ovf_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (flush_eff && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
